pdm_bank: RTL and testbench
===========================

// Module: pdm_bank
// PURPOSE
//  Multi-channel first-order PDM (sigma-delta) modulator bank, successor to the single-channel PDM.
//  Adds per-channel double-buffered levels with an atomic commit, a programmable sample-rate
//  prescaler and per-channel enables. Sits between a register/Wishbone front end and the pads.
//  Typical loads are LEDs, audio and analog trim outputs, each followed by an RC filter.
// PARAMETERS
//  pBits      8  level resolution; duty = level / 2^pBits
//  pChannels  4  number of PDM outputs, >=1
//  pDivBits   8  prescaler width
// PORTS
//  clk     in   1                     system clock, all logic on rising edge
//  rst     in   1                     asynchronous, active-high reset
//  stb     in   1                     write data into shadow[addr] this cycle
//  addr    in   max(1,$clog2(pChannels)) channel select for stb
//  data    in   pBits                 level value written on stb
//  commit  in   1                     request copy of all shadows into active levels
//  div     in   pDivBits              tick period = div+1 clk cycles
//  en      in   pChannels             per-channel enable
//  pdm     out  pChannels             PDM bitstreams, registered
//  tick    out  1                     high for one cycle per modulator sample
//  pending out  1                     commit latched, not yet applied
// BEHAVIOUR
//  Reset
//  - Asynchronous on rst=1; rst has priority over every other input.
//  - Registers cleared: cnt, tick, pending, shadow[], level[], acc[], pdm (all 0).
//  Prescaler
//  - tick is a registered pulse. It is 1 in the cycle after cnt>=div, and cnt then resets to 0.
//  - Otherwise cnt increments by 1.
//  - div=0 gives tick every cycle; in that case tick stays high continuously after the first cycle.
//  - Lowering div below cnt wraps on the next cycle (>= compare). The counter never runs away.
//  Shadow write
//  - stb=1 writes shadow[addr]<=data. An addr >= pChannels is ignored with no side effect.
//  - Shadows never affect the output until a commit is applied.
//  Commit
//  - commit=1 sets pending.
//  - In a tick cycle with pending=1, all level[i]<=shadow[i] together, and pending clears.
//  - The values copied are the registered shadows, so a stb in that same cycle is not included.
//  - commit in a tick cycle sets pending again: the flag is set when commit=1, else cleared on tick.
//  - Repeated commits before a tick merge into a single update.
//  Modulator (per channel i, evaluated only in tick cycles)
//  - acc[i] is pBits+1 bits wide.
//  - Update: acc[i] <= {1'b0, acc[i][pBits-1:0]} + level[i], using level before any same-tick update.
//  - New levels take effect from the following tick.
//  - Output: pdm[i] = acc[i][pBits] (registered carry). pdm holds between ticks.
//  - Exactness: starting from acc=0, any 2^pBits consecutive ticks hold exactly level ones.
//  - Range: level=0 gives constant 0. Full scale (2^pBits-1) gives one 0 per 2^pBits ticks.
//  - en[i]=0: acc[i] is held at 0 and pdm[i]=0 on the next clk, independent of tick.
//  - Re-enabling starts from acc=0. level and shadow are retained while disabled.
//  Simultaneous events
//  - stb and commit in the same non-tick cycle: the write is included in the next transfer.
//  - Reset mid-operation discards pending and all levels. The first tick comes div+1 cycles after rst falls.
// TESTING
//  1. pBits=8, div=0, en=1, level 64 on ch0 -> exactly 64 ones per 256 clk. Ones 4 clk apart after first.
//  2. div=3 -> tick 1 in 4 cycles; pdm changes only on the cycle after tick. Level 128 gives 0101 per tick.
//  3. Write 200 to ch1, no commit -> pdm[1] unchanged for 1000 clk, pending=0. Then commit -> pending=1
//     until the next tick. Levels on every channel switch at the same tick.
//  4. pChannels=3: stb addr=3 data=255 -> all shadows unchanged. pdm unaffected after commit.
//  5. en[2] dropped mid-stream -> pdm[2]=0 next clk. Re-enable: first 256 ticks give exact level count.
//  6. rst asserted between edges with pending=1 and outputs toggling -> pdm, tick and pending drop
//     immediately; no output until a new write+commit.

Source files
------------

// File: rtl/pdm_bank.sv
// Multi-channel first-order PDM modulator bank with double-buffered levels,
// atomic commit, shared sample-rate prescaler and per-channel enables.
`timescale 1ns/1ps

module pdm_chan #(
    parameter int pBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [pBits-1:0] data,
    input  logic             xfer,
    input  logic             tick,
    input  logic             en,
    output logic             pdm
);
    logic [pBits-1:0] shadow;
    logic [pBits-1:0] level;
    logic [pBits:0]   acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow <= '0;
        else if (we)
            shadow <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            level <= '0;
        else if (xfer)
            level <= shadow;
    end

    // The carry out of the low pBits is the output bit; it is dropped before
    // the next add so the accumulator behaves as a modulo-2^pBits phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (!en)
            acc <= '0;
        else if (tick)
            acc <= {1'b0, acc[pBits-1:0]} + {1'b0, level};
    end

    assign pdm = acc[pBits];
endmodule

module pdm_bank #(
    parameter int pBits     = 8,
    parameter int pChannels = 4,
    parameter int pDivBits  = 8,
    localparam int pAddrBits = (pChannels > 1) ? $clog2(pChannels) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stb,
    input  logic [pAddrBits-1:0] addr,
    input  logic [pBits-1:0]     data,
    input  logic                 commit,
    input  logic [pDivBits-1:0]  div,
    input  logic [pChannels-1:0] en,
    output logic [pChannels-1:0] pdm,
    output logic                 tick,
    output logic                 pending
);
    typedef struct packed {
        logic                 stb;
        logic [pAddrBits-1:0] addr;
        logic [pBits-1:0]     data;
    } wr_req_t;

    wr_req_t              req;
    logic [pDivBits-1:0]  cnt;
    logic                 xfer;
    logic [pChannels-1:0] we;

    assign req = '{stb: stb, addr: addr, data: data};

    // >= compare lets a lowered div wrap immediately instead of counting
    // all the way around the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= div) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else if (commit)
            pending <= 1'b1;
        else if (tick)
            pending <= 1'b0;
    end

    assign xfer = tick & pending;

    // Out-of-range addresses match no lane, so they are silently dropped.
    for (genvar i = 0; i < pChannels; i++) begin : g_chan
        assign we[i] = req.stb && (req.addr == pAddrBits'(i));

        pdm_chan #(.pBits(pBits)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .we   (we[i]),
            .data (req.data),
            .xfer (xfer),
            .tick (tick),
            .en   (en[i]),
            .pdm  (pdm[i])
        );
    end
endmodule

// File: tb/tb_pdm_bank.sv
// Directed self-checking bench for pdm_bank (3 channels, 8-bit levels).
`timescale 1ns/1ps

module tb_pdm_bank;
    logic       clk;
    logic       rst;
    logic       stb;
    logic [1:0] addr;
    logic [7:0] data;
    logic       commit;
    logic [7:0] div;
    logic [2:0] en;
    logic [2:0] pdm;
    logic       tick;
    logic       pending;

    int checks = 0;
    int errors = 0;

    pdm_bank #(.pBits(8), .pChannels(3), .pDivBits(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .stb     (stb),
        .addr    (addr),
        .data    (data),
        .commit  (commit),
        .div     (div),
        .en      (en),
        .pdm     (pdm),
        .tick    (tick),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 64) begin
            cycle();
            k++;
        end
        chk("tick_wait", 32'(tick), 32'd1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        stb = 1'b1; addr = a; data = d;
        cycle();
        stb = 1'b0;
    endtask

    task automatic commit_apply();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        chk("pend_set", 32'(pending), 32'd1);
        wait_tick();
        chk("pend_held", 32'(pending), 32'd1);
        cycle();
        chk("pend_clr", 32'(pending), 32'd0);
    endtask

    // Three quiet cycles then a tick: first tick after reset and period for div=3.
    task automatic tick_period(input string tag);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk(tag, 32'(tick), 32'd0);
        end
        cycle();
        chk(tag, 32'(tick), 32'd1);
    endtask

    task automatic count_ticks(input int n, output int c0, output int c1, output int c2,
                               output int first0, output logic gap_ok);
        int last = -1;
        c0 = 0; c1 = 0; c2 = 0; first0 = -1; gap_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_tick();
            cycle();
            if (pdm[0]) begin
                c0++;
                if (first0 < 0) first0 = i;
                else if (i - last != 4) gap_ok = 1'b0;
                last = i;
            end
            c1 += int'(pdm[1]);
            c2 += int'(pdm[2]);
        end
    endtask

    initial begin
        int   c0, c1, c2, f0;
        logic gok;
        logic ok;

        rst = 1'b1; stb = 1'b0; addr = '0; data = '0; commit = 1'b0;
        div = 8'd3; en = 3'b000;

        // Reset state
        cycle(); cycle();
        chk("rst_pdm", 32'(pdm), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);

        // First tick div+1 cycles after release, then one tick per 4 cycles
        rst = 1'b0; en = 3'b111;
        tick_period("first_tick");
        tick_period("tick_period");

        // Level 128 on ch0 at div=3: 0101 on successive ticks, held between ticks
        wr(2'd0, 8'd128);
        commit_apply();
        for (int k = 0; k < 4; k++) begin
            logic p;
            wait_tick();
            cycle();
            p = pdm[0];
            chk("half_seq", 32'(p), 32'(k % 2));
            chk("idle_ch", 32'(pdm[2:1]), 32'd0);
            ok = 1'b1;
            for (int j = 0; j < 3; j++) begin
                cycle();
                if (pdm[0] !== p) ok = 1'b0;
            end
            chk("hold_between", 32'(ok), 32'd1);
        end

        // Shadow write without commit never reaches the output
        wr(2'd1, 8'd200);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (pdm[1] !== 1'b0 || pending !== 1'b0) ok = 1'b0;
        end
        chk("no_commit", 32'(ok), 32'd1);

        // Commit switches all channels at the same tick
        wr(2'd2, 8'd255);
        commit_apply();
        count_ticks(256, c0, c1, c2, f0, gok);
        chk("cnt3_ch0", 32'(c0), 32'd128);
        chk("cnt3_ch1", 32'(c1), 32'd200);
        chk("cnt3_ch2", 32'(c2), 32'd255);

        // Disable all mid-stream at div=0; levels and shadows survive
        div = 8'd0;
        wait_tick();
        en = 3'b000;
        cycle();
        chk("dis_pdm", 32'(pdm), 32'd0);
        wr(2'd0, 8'd64);
        commit_apply();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (pdm !== 3'b000) ok = 1'b0;
        end
        chk("dis_hold", 32'(ok), 32'd1);

        // Re-enable from acc=0: exact counts over 256 ticks, ch0 ones 4 apart
        en = 3'b111;
        count_ticks(256, c0, c1, c2, f0, gok);
        chk("cnt1_ch0", 32'(c0), 32'd64);
        chk("cnt1_first", 32'(f0), 32'd3);
        chk("cnt1_gap", 32'(gok), 32'd1);
        chk("cnt5_ch1", 32'(c1), 32'd200);
        chk("cnt5_ch2", 32'(c2), 32'd255);

        // Zero all levels; last write shares a non-tick cycle with commit
        div = 8'd3;
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd0);
        wait_tick();
        cycle();
        stb = 1'b1; addr = 2'd2; data = 8'd0; commit = 1'b1;
        cycle();
        stb = 1'b0; commit = 1'b0;
        chk("stbc_pend", 32'(pending), 32'd1);
        wait_tick();
        cycle();
        chk("stbc_clr", 32'(pending), 32'd0);
        wait_tick();
        cycle();
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (pdm !== 3'b000) ok = 1'b0;
        end
        chk("zero_out", 32'(ok), 32'd1);

        // Out-of-range address is ignored
        wr(2'd3, 8'd255);
        commit_apply();
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (pdm !== 3'b000) ok = 1'b0;
        end
        chk("oob_addr", 32'(ok), 32'd1);

        // Reset mid-operation with pending set and ch0 high
        div = 8'd0;
        wr(2'd0, 8'd128);
        commit_apply();
        for (int i = 0; i < 4 && pdm[0] !== 1'b0; i++) cycle();
        div = 8'd10;
        cycle();
        stb = 1'b1; addr = 2'd1; data = 8'd50; commit = 1'b1;
        cycle();
        stb = 1'b0; commit = 1'b0;
        chk("pre_rst_pdm", 32'(pdm[0]), 32'd1);
        chk("pre_rst_pend", 32'(pending), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_pdm", 32'(pdm), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_pend", 32'(pending), 32'd0);
        div = 8'd3;
        cycle();
        rst = 1'b0;
        tick_period("post_rst_tick");
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (pdm !== 3'b000 || pending !== 1'b0) ok = 1'b0;
        end
        chk("post_rst_quiet", 32'(ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
